// File: rtl/mx_pkg.sv
// Shared MX element-format definitions: format enum, per-format scaling constants
// and the quantizer FSM state type.
package mx_pkg;

    typedef enum logic [2:0] {
        FMT_E4M3 = 3'd0,
        FMT_E5M2 = 3'd1,
        FMT_E2M3 = 3'd2,
        FMT_E3M2 = 3'd3,
        FMT_E2M1 = 3'd4,
        FMT_INT8 = 3'd5
    } elem_fmt_e;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_SCALE,
        ST_DRAIN
    } qstate_e;

    // bias: element exponent bias (INT8 uses 1 so it rides the subnormal path)
    // max_code: {exp,mant} code of the largest normal, or 127 for INT8
    typedef struct packed {
        logic [3:0] bias;
        logic [2:0] mbits;
        logic [6:0] max_code;
    } fmt_cfg_t;

    localparam logic [7:0] E8M0_NAN = 8'hFF;

    function automatic elem_fmt_e fmt_decode(input logic [2:0] raw);
        case (raw)
            3'd1:    return FMT_E5M2;
            3'd2:    return FMT_E2M3;
            3'd3:    return FMT_E3M2;
            3'd4:    return FMT_E2M1;
            3'd5:    return FMT_INT8;
            default: return FMT_E4M3;
        endcase
    endfunction

    function automatic logic [7:0] fmt_emax(input elem_fmt_e fmt);
        case (fmt)
            FMT_E5M2: return 8'd15;
            FMT_E2M3: return 8'd2;
            FMT_E3M2: return 8'd4;
            FMT_E2M1: return 8'd2;
            FMT_INT8: return 8'd0;
            default:  return 8'd8;
        endcase
    endfunction

    function automatic logic [2:0] fmt_ebits(input elem_fmt_e fmt);
        case (fmt)
            FMT_E5M2: return 3'd5;
            FMT_E2M3: return 3'd2;
            FMT_E3M2: return 3'd3;
            FMT_E2M1: return 3'd2;
            FMT_INT8: return 3'd0;
            default:  return 3'd4;
        endcase
    endfunction

    function automatic fmt_cfg_t fmt_cfg(input elem_fmt_e fmt);
        case (fmt)
            FMT_E5M2: return '{bias: 4'd15, mbits: 3'd2, max_code: 7'd123};
            FMT_E2M3: return '{bias: 4'd1,  mbits: 3'd3, max_code: 7'd31};
            FMT_E3M2: return '{bias: 4'd3,  mbits: 3'd2, max_code: 7'd31};
            FMT_E2M1: return '{bias: 4'd1,  mbits: 3'd1, max_code: 7'd7};
            FMT_INT8: return '{bias: 4'd1,  mbits: 3'd6, max_code: 7'd127};
            default:  return '{bias: 4'd7,  mbits: 3'd3, max_code: 7'd126};
        endcase
    endfunction

endpackage

// File: rtl/mx_elem_cvt.sv
// Combinational FP32 -> MX element converter: scales by 2^-(X-127), rounds to
// nearest even, handles element subnormals/underflow and saturates to max normal.
module mx_elem_cvt
    import mx_pkg::*;
(
    input  logic        sign_i,
    input  logic [7:0]  exp_i,
    input  logic [22:0] mant_i,
    input  logic [7:0]  x_i,
    input  elem_fmt_e   fmt_i,
    output logic        sign_o,
    output logic [4:0]  exp_o,
    output logic [6:0]  mant_o
);

    fmt_cfg_t           cfg;
    logic               is_int;
    logic signed [10:0] e_b;
    logic signed [10:0] e_eff;
    logic signed [10:0] sh_full;
    logic [4:0]         sh;
    logic [24:0]        sig;
    logic [24:0]        q0;
    logic [24:0]        q;
    logic [24:0]        lsb_mask;
    logic [24:0]        code;
    logic               rnd;
    logic               sticky;
    logic               sat;
    logic [6:0]         res;
    logic [6:0]         mant_mask;

    always_comb begin
        cfg    = fmt_cfg(fmt_i);
        is_int = (fmt_i == FMT_INT8);

        e_b = $signed({3'b000, exp_i}) - $signed({3'b000, x_i}) + $signed({7'b0, cfg.bias});
        // Below the normal range the code is built as a subnormal; INT8 always is one.
        if (is_int || (e_b < 11'sd1)) begin
            e_eff = 11'sd1;
        end else begin
            e_eff = e_b;
        end

        sh_full = 11'sd23 - $signed({8'b0, cfg.mbits}) + (e_eff - e_b);
        if (sh_full > 11'sd25) begin
            sh = 5'd25;
        end else if (sh_full < 11'sd1) begin
            sh = 5'd1;
        end else begin
            sh = sh_full[4:0];
        end

        sig      = {2'b01, mant_i};
        q0       = sig >> sh;
        rnd      = sig[sh - 5'd1];
        lsb_mask = (25'd1 << (sh - 5'd1)) - 25'd1;
        sticky   = |(sig & lsb_mask);
        q        = q0 + {24'd0, rnd & (sticky | q0[0])};

        // Rounding carry out of the mantissa ripples straight into the exponent field.
        code = (25'($unsigned(e_eff - 11'sd1)) << cfg.mbits) + q;
        sat  = (is_int && (e_b > 11'sd1)) || (code > {18'd0, cfg.max_code});
        res  = sat ? cfg.max_code : code[6:0];
        if (exp_i == 8'd0) begin
            res = 7'd0;
        end

        mant_mask = is_int ? 7'h7F : 7'((8'd1 << cfg.mbits) - 8'd1);
        sign_o    = sign_i;
        exp_o     = is_int ? 5'd0 : 5'(res >> cfg.mbits);
        mant_o    = res & mant_mask;
    end

endmodule

// File: rtl/mx_block_quantizer.sv
// MX block quantizer: buffers BLOCK_SIZE FP32 words, derives the E8M0 shared
// exponent from the block maximum and drains one element code per handshake.
module mx_block_quantizer
    import mx_pkg::*;
#(
    parameter int BLOCK_SIZE = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  elem_fmt_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        in_sign_i,
    input  logic [7:0]  in_exp_i,
    input  logic [22:0] in_mant_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        out_sign_o,
    output logic [4:0]  out_exp_o,
    output logic [6:0]  out_mant_o,
    output logic [7:0]  shared_exp_o,
    output logic        out_first_o,
    output logic        out_last_o
);

    // state    | meaning
    // ST_FILL  | accepting words, tracking max exponent and NaN/Inf
    // ST_SCALE | one cycle deriving the shared exponent
    // ST_DRAIN | emitting one element per output handshake

    localparam int            CW       = $clog2(BLOCK_SIZE);
    localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_SIZE - 1);

    qstate_e       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    max_q, max_d;
    logic [7:0]    sx_q, sx_d;
    logic          nan_q, nan_d;
    elem_fmt_e     fmt_q, fmt_d;
    logic [31:0]   buf_q [BLOCK_SIZE];
    logic [31:0]   buf_d [BLOCK_SIZE];
    logic [7:0]    emax;
    logic [31:0]   cur;
    logic          c_sign;
    logic [4:0]    c_exp;
    logic [6:0]    c_mant;
    logic          drain;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        nan_d   = nan_q;
        fmt_d   = fmt_q;
        sx_d    = sx_q;
        buf_d   = buf_q;
        emax    = fmt_emax(fmt_q);

        unique case (state_q)
            ST_FILL: begin
                if (in_valid_i) begin
                    buf_d[cnt_q] = {in_sign_i, in_exp_i, in_mant_i};
                    // The first word restarts max/NaN tracking and latches the format.
                    if (cnt_q == '0) begin
                        max_d = in_exp_i;
                        nan_d = (in_exp_i == 8'hFF);
                        fmt_d = fmt_decode(elem_fmt_i);
                    end else begin
                        if (in_exp_i > max_q) begin
                            max_d = in_exp_i;
                        end
                        nan_d = nan_q | (in_exp_i == 8'hFF);
                    end
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = ST_SCALE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_SCALE: begin
                if (nan_q) begin
                    sx_d = E8M0_NAN;
                end else if (max_q > emax) begin
                    sx_d = max_q - emax;
                end else begin
                    sx_d = 8'd0;
                end
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_ready_i) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = ST_FILL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            max_q   <= 8'd0;
            nan_q   <= 1'b0;
            fmt_q   <= FMT_E4M3;
            sx_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            nan_q   <= nan_d;
            fmt_q   <= fmt_d;
            sx_q    <= sx_d;
        end
    end

    // Buffer needs no reset: it is only observed during DRAIN, after a full refill.
    always_ff @(posedge clk_i) begin
        buf_q <= buf_d;
    end

    assign cur = buf_q[cnt_q];

    mx_elem_cvt u_cvt (
        .sign_i (cur[31]),
        .exp_i  (cur[30:23]),
        .mant_i (cur[22:0]),
        .x_i    (sx_q),
        .fmt_i  (fmt_q),
        .sign_o (c_sign),
        .exp_o  (c_exp),
        .mant_o (c_mant)
    );

    always_comb begin
        drain        = (state_q == ST_DRAIN);
        in_ready_o   = (state_q == ST_FILL);
        out_valid_o  = drain;
        out_sign_o   = drain & c_sign;
        out_exp_o    = drain ? c_exp : 5'd0;
        out_mant_o   = drain ? c_mant : 7'd0;
        out_first_o  = drain && (cnt_q == '0);
        out_last_o   = drain && (cnt_q == LAST_IDX);
        shared_exp_o = sx_q;
    end

endmodule
